// File: rtl/sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_pkg : shared constants and types for the SD command controller     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sd_pkg;

  localparam logic [1:0] RESP_NONE  = 2'd0;
  localparam logic [1:0] RESP_SHORT = 2'd1;
  localparam logic [1:0] RESP_LONG  = 2'd2;
  localparam logic [1:0] RESP_RSVD  = 2'd3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_WAIT_RESP = 3'd2;
  localparam logic [2:0] ST_RECV      = 3'd3;
  localparam logic [2:0] ST_CHECK     = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // Short-response field positions within the 135-bit receiver word
  localparam int SR_IDX_MSB = 132;
  localparam int SR_IDX_LSB = 127;
  localparam int SR_ARG_MSB = 126;
  localparam int SR_ARG_LSB = 95;
  localparam int SR_CRC_MSB = 94;
  localparam int SR_CRC_LSB = 88;
  localparam int SR_END_BIT = 87;

  localparam logic [6:0] CRC7_POLY  = 7'h09;
  localparam int         CNT_W      = 8;
  localparam int         CHECK_BITS = 40;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
    logic [1:0]  rtype;
    logic        chk_index;
    logic        chk_crc;
  } cmd_req_t;

  function automatic logic [1:0] norm_resp_type(input logic [1:0] t);
    return (t == RESP_RSVD) ? RESP_SHORT : t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_cmd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_cmd_ctrl_if : host request, CMD TX/RX and status bundle            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface sd_cmd_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_index;
  logic [31:0]  req_arg;
  logic [1:0]   req_resp_type;
  logic         req_chk_index;
  logic         req_chk_crc;
  logic         tx_start;
  logic [5:0]   tx_index;
  logic [31:0]  tx_arg;
  logic         tx_done;
  logic         rx_en;
  logic         rx_R2;
  logic         rx_started;
  logic         rx_finished;
  logic [134:0] rx_response;
  logic         done;
  logic [127:0] resp;
  logic [5:0]   resp_index;
  logic         err_timeout;
  logic         err_index;
  logic         err_crc;
  logic         err_end;

  modport master (
    output req_valid, req_index, req_arg, req_resp_type, req_chk_index, req_chk_crc,
    output tx_done, rx_started, rx_finished, rx_response,
    input  req_ready, tx_start, tx_index, tx_arg, rx_en, rx_R2,
    input  done, resp, resp_index, err_timeout, err_index, err_crc, err_end
  );

  modport slave (
    input  req_valid, req_index, req_arg, req_resp_type, req_chk_index, req_chk_crc,
    input  tx_done, rx_started, rx_finished, rx_response,
    output req_ready, tx_start, tx_index, tx_arg, rx_en, rx_R2,
    output done, resp, resp_index, err_timeout, err_index, err_crc, err_end
  );
endinterface
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_crc7 : serial CRC7 (x^7+x^3+1), MSB first, synchronous clear       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);
  logic [6:0] crc_q, crc_d;
  logic       feedback;

  always_comb begin
    feedback = din ^ crc_q[6];
    crc_d    = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;
endmodule
`default_nettype wire

// File: rtl/sd_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sd_cmd_ctrl : sequences one SD CMD-line transaction and checks reply  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sd_cmd_ctrl
  import sd_pkg::*;
#(
  parameter int NCR_MAX  = 64,
  parameter int RESP_MAX = 160
) (
  input logic          clk,
  input logic          reset,
  sd_cmd_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] NCR_LAST  = CNT_W'(NCR_MAX - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_MAX - 1);
  localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(CHECK_BITS);

  logic [2:0]       state_q, state_d;
  cmd_req_t         req_q, req_d;
  logic             tx_start_q, tx_start_d;
  logic             rx_en_q, rx_en_d;
  logic             rx_r2_q, rx_r2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [39:0]      shreg_q, shreg_d;
  logic [127:0]     resp_q, resp_d;
  logic [5:0]       resp_index_q, resp_index_d;
  logic [6:0]       rcrc_q, rcrc_d;
  logic             rend_q, rend_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_index_q, err_index_d;
  logic             err_crc_q, err_crc_d;
  logic             err_end_q, err_end_d;

  logic [6:0]       crc_calc;
  logic             crc_clear;
  logic             crc_en;
  logic             rx_unused_ok;

  assign rx_unused_ok = ^bus.rx_response[134:133];

  assign crc_clear = (state_q == ST_RECV) && bus.rx_finished && !rx_r2_q;
  assign crc_en    = (state_q == ST_CHECK) && (cnt_q < CHK_LAST);

  sd_crc7 u_crc7 (
    .clk   (clk),
    .reset (reset),
    .clear (crc_clear),
    .en    (crc_en),
    .din   (shreg_q[39]),
    .crc   (crc_calc)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    tx_start_d    = 1'b0;
    rx_en_d       = rx_en_q;
    rx_r2_d       = rx_r2_q;
    cnt_d         = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    shreg_d       = shreg_q;
    resp_d        = resp_q;
    resp_index_d  = resp_index_q;
    rcrc_d        = rcrc_q;
    rend_d        = rend_q;
    err_timeout_d = err_timeout_q;
    err_index_d   = err_index_q;
    err_crc_d     = err_crc_q;
    err_end_d     = err_end_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          req_d.index     = bus.req_index;
          req_d.arg       = bus.req_arg;
          req_d.rtype     = norm_resp_type(bus.req_resp_type);
          req_d.chk_index = bus.req_chk_index;
          req_d.chk_crc   = bus.req_chk_crc;
          err_timeout_d   = 1'b0;
          err_index_d     = 1'b0;
          err_crc_d       = 1'b0;
          err_end_d       = 1'b0;
          tx_start_d      = 1'b1;
          state_d         = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.tx_done) begin
          cnt_d = '0;
          if (req_q.rtype == RESP_NONE) begin
            state_d = ST_DONE;
          end else begin
            rx_en_d = 1'b1;
            rx_r2_d = (req_q.rtype == RESP_LONG);
            state_d = ST_WAIT_RESP;
          end
        end
      end
      ST_WAIT_RESP: begin
        if (bus.rx_started) begin
          cnt_d   = '0;
          state_d = ST_RECV;
        end else if (cnt_q == NCR_LAST) begin
          err_timeout_d = 1'b1;
          rx_en_d       = 1'b0;
          rx_r2_d       = 1'b0;
          state_d       = ST_DONE;
        end
      end
      ST_RECV: begin
        // A finish on the limit cycle is still a valid response
        if (bus.rx_finished) begin
          rx_en_d = 1'b0;
          rx_r2_d = 1'b0;
          cnt_d   = '0;
          if (rx_r2_q) begin
            resp_d  = bus.rx_response[127:0];
            state_d = ST_DONE;
          end else begin
            resp_d       = {96'b0, bus.rx_response[SR_ARG_MSB:SR_ARG_LSB]};
            resp_index_d = bus.rx_response[SR_IDX_MSB:SR_IDX_LSB];
            rcrc_d       = bus.rx_response[SR_CRC_MSB:SR_CRC_LSB];
            rend_d       = bus.rx_response[SR_END_BIT];
            shreg_d      = {2'b00, bus.rx_response[SR_IDX_MSB:SR_IDX_LSB],
                            bus.rx_response[SR_ARG_MSB:SR_ARG_LSB]};
            state_d      = ST_CHECK;
          end
        end else if (cnt_q == RESP_LAST) begin
          err_timeout_d = 1'b1;
          rx_en_d       = 1'b0;
          rx_r2_d       = 1'b0;
          state_d       = ST_DONE;
        end
      end
      ST_CHECK: begin
        if (cnt_q < CHK_LAST) begin
          shreg_d = {shreg_q[38:0], 1'b0};
        end else begin
          err_crc_d   = req_q.chk_crc && (crc_calc != rcrc_q);
          err_index_d = req_q.chk_index && (resp_index_q != req_q.index);
          err_end_d   = ~rend_q;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      tx_start_q    <= 1'b0;
      rx_en_q       <= 1'b0;
      rx_r2_q       <= 1'b0;
      cnt_q         <= '0;
      shreg_q       <= '0;
      resp_q        <= '0;
      resp_index_q  <= '0;
      rcrc_q        <= '0;
      rend_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_index_q   <= 1'b0;
      err_crc_q     <= 1'b0;
      err_end_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      tx_start_q    <= tx_start_d;
      rx_en_q       <= rx_en_d;
      rx_r2_q       <= rx_r2_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      resp_q        <= resp_d;
      resp_index_q  <= resp_index_d;
      rcrc_q        <= rcrc_d;
      rend_q        <= rend_d;
      err_timeout_q <= err_timeout_d;
      err_index_q   <= err_index_d;
      err_crc_q     <= err_crc_d;
      err_end_q     <= err_end_d;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_index    = req_q.index;
  assign bus.tx_arg      = req_q.arg;
  assign bus.rx_en       = rx_en_q;
  assign bus.rx_R2       = rx_r2_q;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.resp        = resp_q;
  assign bus.resp_index  = resp_index_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_index   = err_index_q;
  assign bus.err_crc     = err_crc_q;
  assign bus.err_end     = err_end_q;
endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sd_cmd_ctrl : scoreboard bench for the SD command controller       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sd_cmd_ctrl;
  localparam int NCR  = 64;
  localparam int RSPM = 160;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sd_cmd_ctrl_if bus ();

  sd_cmd_ctrl #(.NCR_MAX(NCR), .RESP_MAX(RSPM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int           cyc;
    logic [3:0]   errs;   // {timeout, index, crc, end}
    bit           chk_resp;
    logic [127:0] resp;
    bit           chk_ridx;
    logic [5:0]   ridx;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] m;
    m = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    end
    return m[6:0];
  endfunction

  function automatic logic [134:0] mk_short(input logic [5:0] idx, input logic [31:0] arg,
                                            input logic [6:0] crc, input logic endb);
    logic [134:0] r;
    r = '0;
    r[132:127] = idx;
    r[126:95]  = arg;
    r[94:88]   = crc;
    r[87]      = endb;
    return r;
  endfunction

  function automatic logic [134:0] rand135();
    logic [134:0] r;
    for (int i = 0; i < 135; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
        end else begin
          me = sb.pop_front();
          check("done_cycle", 128'(cyc), 128'(me.cyc));
          check("err_flags", 128'({bus.err_timeout, bus.err_index, bus.err_crc, bus.err_end}),
                128'(me.errs));
          check("rx_en_at_done", 128'(bus.rx_en), 128'(0));
          if (me.chk_resp) check("resp", bus.resp, me.resp);
          if (me.chk_ridx) check("resp_index", 128'(bus.resp_index), 128'(me.ridx));
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_done: got done=0, expected done=1 at cycle %0d", sb[0].cyc);
        sb.delete(0);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!bus.req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ok = bus.req_ready;
  endtask

  task automatic do_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input logic ci, input logic cc, input int tx_gap, input int st_gap,
                        input int fin_gap, input logic [134:0] rsp);
    exp_t e;
    int c, s, f;
    logic [1:0] t;
    bit ok;
    logic [5:0] ridx;
    logic [31:0] rarg;
    t = (rt == 2'd3) ? 2'd1 : rt;
    e.cyc = 0; e.errs = 4'b0; e.chk_resp = 0; e.resp = '0; e.chk_ridx = 0; e.ridx = '0;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_ready_wait: got req_ready=0, expected 1 within bound");
      return;
    end
    bus.req_valid = 1'b1; bus.req_index = idx; bus.req_arg = arg;
    bus.req_resp_type = rt; bus.req_chk_index = ci; bus.req_chk_crc = cc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_index = 6'($urandom); bus.req_arg = $urandom; bus.req_resp_type = 2'($urandom);
    check("tx_start", 128'(bus.tx_start), 128'(1));
    check("tx_index", 128'(bus.tx_index), 128'(idx));
    check("tx_arg", 128'(bus.tx_arg), 128'(arg));
    check("rx_en_send", 128'(bus.rx_en), 128'(0));
    for (int k = 0; k < tx_gap; k++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (k == 0) check("tx_start_pulse", 128'(bus.tx_start), 128'(0));
    end
    bus.req_valid = 1'b0;
    bus.tx_done = 1'b1;
    c = cyc;
    if (t == 2'd0) begin
      e.cyc = c + 1;
      sb.push_back(e);
      @(negedge clk);
      bus.tx_done = 1'b0;
    end else begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      check("rx_en_wait", 128'(bus.rx_en), 128'(1));
      check("rx_R2", 128'(bus.rx_R2), 128'(t == 2'd2));
      if (st_gap > NCR) begin
        e.cyc = c + NCR + 1; e.errs = 4'b1000;
        sb.push_back(e);
      end else begin
        repeat (st_gap - 1) @(negedge clk);
        bus.rx_started = 1'b1;
        s = cyc;
        @(negedge clk);
        bus.rx_started = 1'b0;
        if (fin_gap > RSPM) begin
          e.cyc = s + RSPM + 1; e.errs = 4'b1000;
          sb.push_back(e);
        end else begin
          repeat (fin_gap - 1) @(negedge clk);
          bus.rx_response = rsp;
          bus.rx_finished = 1'b1;
          f = cyc;
          if (t == 2'd2) begin
            e.cyc = f + 1; e.chk_resp = 1; e.resp = rsp[127:0];
          end else begin
            ridx = rsp[132:127];
            rarg = rsp[126:95];
            e.cyc = f + 42; e.chk_resp = 1; e.resp = {96'b0, rarg};
            e.chk_ridx = 1; e.ridx = ridx;
            e.errs = {1'b0, ci && (ridx != idx),
                      cc && (rsp[94:88] != crc7_ref({2'b00, ridx, rarg})), !rsp[87]};
          end
          sb.push_back(e);
          @(negedge clk);
          bus.rx_finished = 1'b0;
        end
      end
    end
    while (cyc <= e.cyc) @(negedge clk);
  endtask

  logic [134:0] rsp;
  logic [6:0]   gcrc;
  logic [5:0]   r_idx, r_ridx;
  logic [31:0]  r_arg;
  logic [1:0]   r_rt;
  logic [6:0]   r_crc;
  int           r_sg, r_fg, r_sel;
  bit           ok;

  initial begin
    bus.req_valid = 0; bus.req_index = '0; bus.req_arg = '0; bus.req_resp_type = '0;
    bus.req_chk_index = 0; bus.req_chk_crc = 0; bus.tx_done = 0;
    bus.rx_started = 0; bus.rx_finished = 0; bus.rx_response = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 128'(bus.req_ready), 128'(1));
    check("rst_pulses", 128'({bus.tx_start, bus.rx_en, bus.rx_R2, bus.done}), 128'(0));
    check("rst_resp", bus.resp, 128'(0));
    check("rst_errs", 128'({bus.err_timeout, bus.err_index, bus.err_crc, bus.err_end}), 128'(0));
    reset = 1'b0;

    do_txn(6'd0, 32'h0, 2'd0, 0, 0, 2, 0, 0, '0);
    gcrc = crc7_ref({2'b00, 6'd17, 32'h0000_0900});
    do_txn(6'd17, 32'h200, 2'd1, 1, 1, 3, 5, 48, mk_short(6'd17, 32'h900, gcrc, 1'b1));
    do_txn(6'd17, 32'h200, 2'd1, 1, 1, 1, 3, 48, mk_short(6'd17, 32'h980, gcrc, 1'b1));
    do_txn(6'd17, 32'h200, 2'd1, 1, 1, 1, 3, 48,
           mk_short(6'd18, 32'h900, crc7_ref({2'b00, 6'd18, 32'h900}), 1'b1));
    do_txn(6'd17, 32'h200, 2'd3, 1, 1, 0, 2, 48, mk_short(6'd17, 32'h900, gcrc, 1'b0));
    rsp = '0;
    rsp[127:0] = 128'h1D41_4453_4436_3447_3012_3456_7801_2345;
    rsp[134:128] = 7'h3F;
    do_txn(6'd2, 32'h0, 2'd2, 0, 0, 2, 4, 130, rsp);
    do_txn(6'd13, 32'h1234, 2'd1, 1, 1, 2, NCR + 1, 0, '0);
    do_txn(6'd13, 32'h1234, 2'd1, 1, 1, 2, NCR, RSPM,
           mk_short(6'd13, 32'hCAFE, crc7_ref({2'b00, 6'd13, 32'hCAFE}), 1'b1));
    do_txn(6'd9, 32'h5, 2'd2, 0, 0, 2, 7, RSPM + 1, '0);

    // Reset while the response is being received
    @(negedge clk);
    wait_ready(ok);
    bus.req_valid = 1; bus.req_index = 6'd17; bus.req_arg = 32'h200; bus.req_resp_type = 2'd2;
    @(negedge clk);
    bus.req_valid = 0; bus.tx_done = 1;
    @(negedge clk);
    bus.tx_done = 0;
    @(negedge clk);
    bus.rx_started = 1;
    @(negedge clk);
    bus.rx_started = 0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", 128'(bus.req_ready), 128'(1));
    check("abort_pulses", 128'({bus.tx_start, bus.rx_en, bus.rx_R2, bus.done}), 128'(0));
    check("abort_resp", bus.resp, 128'(0));
    check("abort_tx", 128'({bus.tx_index, bus.tx_arg, bus.resp_index}), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    do_txn(6'd17, 32'h200, 2'd1, 1, 1, 1, 4, 48, mk_short(6'd17, 32'h900, gcrc, 1'b1));

    for (int n = 0; n < 40; n++) begin
      r_idx = 6'($urandom);
      r_arg = $urandom;
      r_rt  = 2'($urandom_range(0, 3));
      r_sel = $urandom_range(0, 9);
      r_sg  = (r_sel == 0) ? NCR + 1 : (r_sel == 1) ? NCR : $urandom_range(1, 20);
      r_sel = $urandom_range(0, 9);
      r_fg  = (r_sel == 0) ? RSPM + 1 : (r_sel == 1) ? RSPM : $urandom_range(1, 20);
      if (r_rt == 2'd2) begin
        rsp = rand135();
      end else begin
        r_ridx = ($urandom_range(0, 3) == 0) ? r_idx ^ 6'($urandom_range(1, 63)) : r_idx;
        r_crc  = crc7_ref({2'b00, r_ridx, r_arg ^ 32'h5A5A_0000});
        if ($urandom_range(0, 3) == 0) r_crc = r_crc ^ 7'($urandom_range(1, 127));
        rsp = mk_short(r_ridx, r_arg ^ 32'h5A5A_0000, r_crc, 1'($urandom_range(0, 4) != 0));
      end
      do_txn(r_idx, r_arg, r_rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 4), r_sg, r_fg, rsp);
    end

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
